// File: rtl/motion_mask_gen.sv
// motion_mask_gen
// Compares each RGB pixel with its co-located background pixel. It thresholds
// the luma difference and emits a motion flag, an end-of-frame tag and the
// delayed pixel through a fixed 3-stage pipeline. Motion is suppressed for
// the first frame after reset, while the background is not yet valid.
// Optional feature macro: MOTION_BG_UPDATE_EN. When it is defined,
// bg_pixel_out carries a running-average background instead of the delayed
// bg_pixel_in.
module motion_mask_gen #(
    parameter int WIDTH_BITS  = 11,
    parameter int HEIGHT_BITS = 10,
    parameter int THRESH_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            rbg_pixel_in,
    input  logic [31:0]            bg_pixel_in,
    input  logic [WIDTH_BITS-1:0]  width,
    input  logic [HEIGHT_BITS-1:0] height,
    input  logic [THRESH_BITS-1:0] threshold,
    output logic                   motion_pixel,
    output logic [31:0]            rbg_pixel,
    output logic                   last_in_frame,
    output logic                   pixel_valid,
    output logic [31:0]            bg_pixel_out
);

    localparam int CMP_BITS = (THRESH_BITS > 8) ? THRESH_BITS : 8;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Y = (77R + 150G + 29B) >> 8. The weights sum to 256, so 16 bits are enough.
    function automatic logic [7:0] luma(input logic [31:0] pix);
        logic [15:0] acc;
        acc = 16'(pix[23:16]) * 16'd77 + 16'(pix[15:8]) * 16'd150 + 16'(pix[7:0]) * 16'd29;
        return acc[15:8];
    endfunction

`ifdef MOTION_BG_UPDATE_EN
    // One channel of the running average: bg + ((cur - bg) >>> 3).
    function automatic logic [7:0] bg_blend(input logic [7:0] cur, input logic [7:0] bg);
        logic signed [8:0] d;
        d = $signed({1'b0, cur}) - $signed({1'b0, bg});
        d = d >>> 3;
        return bg + d[7:0];
    endfunction
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH_BITS-1:0]  r_x;
    logic [HEIGHT_BITS-1:0] r_y;
    logic [WIDTH_BITS-1:0]  r_width;
    logic [HEIGHT_BITS-1:0] r_height;
    logic                   w_frame_start;
    logic [WIDTH_BITS-1:0]  w_width_eff;
    logic [HEIGHT_BITS-1:0] w_height_eff;
    logic                   w_x_last;
    logic                   w_y_last;
    logic                   w_last_pix;

    logic                   r_s1_valid, r_s1_last, r_s1_warm;
    logic [31:0]            r_s1_pix, r_s1_bg;
    logic [THRESH_BITS-1:0] r_s1_thr;
    logic [7:0]             r_s1_luma_cur, r_s1_luma_bg;

    logic                   r_s2_valid, r_s2_last, r_s2_warm;
    logic [31:0]            r_s2_pix, r_s2_bg;
    logic [THRESH_BITS-1:0] r_s2_thr;
    logic [7:0]             r_s2_diff;

    logic [7:0]             w_diff;
    logic                   w_motion;
    logic [31:0]            w_bg_next;

    // Raster position decode. At (0,0) the live frame size is used, because it is sampled there.
    always_comb begin
        w_frame_start = (r_x == {WIDTH_BITS{1'b0}}) && (r_y == {HEIGHT_BITS{1'b0}});
        w_width_eff   = r_width;
        w_height_eff  = r_height;
        if (w_frame_start) begin
            w_width_eff  = width;
            w_height_eff = height;
        end else begin
            w_width_eff  = r_width;
            w_height_eff = r_height;
        end
        w_x_last   = (r_x == (w_width_eff - WIDTH_BITS'(1)));
        w_y_last   = (r_y == (w_height_eff - HEIGHT_BITS'(1)));
        w_last_pix = w_x_last && w_y_last;
    end

    // Raster counters and frame-size shadows. They advance only on accepted pixels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x      <= {WIDTH_BITS{1'b0}};
            r_y      <= {HEIGHT_BITS{1'b0}};
            r_width  <= {WIDTH_BITS{1'b0}};
            r_height <= {HEIGHT_BITS{1'b0}};
        end else if (enable) begin
            if (w_frame_start) begin
                r_width  <= width;
                r_height <= height;
            end
            if (w_x_last) begin
                r_x <= {WIDTH_BITS{1'b0}};
                if (w_y_last) begin
                    r_y <= {HEIGHT_BITS{1'b0}};
                end else begin
                    r_y <= r_y + HEIGHT_BITS'(1);
                end
            end else begin
                r_x <= r_x + WIDTH_BITS'(1);
            end
        end
    end

    // Warmup/run state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_WARMUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leave warmup when the last pixel of the first frame is accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WARMUP: begin
                if (enable && w_last_pix) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_WARMUP;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_WARMUP;
        endcase
    end

    // Stage 1: capture the pixel, its framing and warmup tag, and both lumas.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_warm     <= 1'b1;
            r_s1_pix      <= 32'd0;
            r_s1_bg       <= 32'd0;
            r_s1_thr      <= {THRESH_BITS{1'b0}};
            r_s1_luma_cur <= 8'd0;
            r_s1_luma_bg  <= 8'd0;
        end else begin
            r_s1_valid    <= enable;
            r_s1_last     <= enable && w_last_pix;
            r_s1_warm     <= (r_state == ST_WARMUP);
            r_s1_pix      <= rbg_pixel_in;
            r_s1_bg       <= bg_pixel_in;
            r_s1_thr      <= threshold;
            r_s1_luma_cur <= luma(rbg_pixel_in);
            r_s1_luma_bg  <= luma(bg_pixel_in);
        end
    end

    // Absolute luma difference.
    always_comb begin
        w_diff = 8'd0;
        if (r_s1_luma_cur >= r_s1_luma_bg) begin
            w_diff = r_s1_luma_cur - r_s1_luma_bg;
        end else begin
            w_diff = r_s1_luma_bg - r_s1_luma_cur;
        end
    end

    // Stage 2: hold the difference alongside the carried pixel data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_warm  <= 1'b1;
            r_s2_pix   <= 32'd0;
            r_s2_bg    <= 32'd0;
            r_s2_thr   <= {THRESH_BITS{1'b0}};
            r_s2_diff  <= 8'd0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_warm  <= r_s1_warm;
            r_s2_pix   <= r_s1_pix;
            r_s2_bg    <= r_s1_bg;
            r_s2_thr   <= r_s1_thr;
            r_s2_diff  <= w_diff;
        end
    end

    // Strict threshold compare, forced off in warmup; background write-back value.
    always_comb begin
        w_motion = (!r_s2_warm) && (CMP_BITS'(r_s2_diff) > CMP_BITS'(r_s2_thr));
`ifdef MOTION_BG_UPDATE_EN
        w_bg_next = 32'd0;
        if (r_s2_warm) begin
            w_bg_next = r_s2_pix;
        end else begin
            w_bg_next = {r_s2_bg[31:24],
                         bg_blend(r_s2_pix[23:16], r_s2_bg[23:16]),
                         bg_blend(r_s2_pix[15:8],  r_s2_bg[15:8]),
                         bg_blend(r_s2_pix[7:0],   r_s2_bg[7:0])};
        end
`else
        w_bg_next = r_s2_bg;
`endif
    end

    // Stage 3: registered outputs. Pixel data holds across bubbles; flags drop to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_valid   <= 1'b0;
            motion_pixel  <= 1'b0;
            last_in_frame <= 1'b0;
            rbg_pixel     <= 32'd0;
            bg_pixel_out  <= 32'd0;
        end else if (r_s2_valid) begin
            pixel_valid   <= 1'b1;
            motion_pixel  <= w_motion;
            last_in_frame <= r_s2_last;
            rbg_pixel     <= r_s2_pix;
            bg_pixel_out  <= w_bg_next;
        end else begin
            pixel_valid   <= 1'b0;
            motion_pixel  <= 1'b0;
            last_in_frame <= 1'b0;
        end
    end

endmodule

// File: tb/tb_motion_mask_gen.sv
// Self-checking bench for motion_mask_gen. A frame-level reference model
// predicts every output cycle, and a 3-deep queue aligns the predictions
// with the pipeline. Works with or without MOTION_BG_UPDATE_EN.
module tb_motion_mask_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rbg_pixel_in = 32'd0;
    logic [31:0] bg_pixel_in = 32'd0;
    logic [10:0] width = 11'd1;
    logic [9:0]  height = 10'd1;
    logic [7:0]  threshold = 8'd0;
    logic        motion_pixel;
    logic [31:0] rbg_pixel;
    logic        last_in_frame;
    logic        pixel_valid;
    logic [31:0] bg_pixel_out;

    motion_mask_gen #(.WIDTH_BITS(11), .HEIGHT_BITS(10), .THRESH_BITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rbg_pixel_in (rbg_pixel_in),
        .bg_pixel_in  (bg_pixel_in),
        .width        (width),
        .height       (height),
        .threshold    (threshold),
        .motion_pixel (motion_pixel),
        .rbg_pixel    (rbg_pixel),
        .last_in_frame(last_in_frame),
        .pixel_valid  (pixel_valid),
        .bg_pixel_out (bg_pixel_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        motion;
        logic        last;
        logic [31:0] rbg;
        logic [31:0] bgo;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_idx, m_frame, m_w, m_h;
    logic [31:0] m_last_rbg, m_last_bgo;

    function automatic int luma_of(input logic [31:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    function automatic logic [31:0] blend_of(input logic [31:0] cur, input logic [31:0] bg);
        logic [31:0] r;
        int d, v;
        r = bg;
        for (int c = 0; c < 3; c++) begin
            d = int'(cur[c*8 +: 8]) - int'(bg[c*8 +: 8]);
            v = int'(bg[c*8 +: 8]) + (d >>> 3);
            r[c*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic en, input logic [31:0] cur, input logic [31:0] bg,
                              input logic [7:0] thr);
        exp_t e;
        int   dy;
        if (en) begin
            dy = luma_of(cur) - luma_of(bg);
            if (dy < 0) dy = -dy;
            e.valid  = 1'b1;
            e.last   = (m_idx == m_w * m_h - 1);
            e.motion = (m_frame > 0) && (dy > int'(thr));
            e.rbg    = cur;
`ifdef MOTION_BG_UPDATE_EN
            e.bgo    = (m_frame == 0) ? cur : blend_of(cur, bg);
`else
            e.bgo    = bg;
`endif
            m_last_rbg = e.rbg;
            m_last_bgo = e.bgo;
            m_idx++;
            if (m_idx == m_w * m_h) begin
                m_idx = 0;
                m_frame++;
            end
        end else begin
            e.valid  = 1'b0;
            e.last   = 1'b0;
            e.motion = 1'b0;
            e.rbg    = m_last_rbg;
            e.bgo    = m_last_bgo;
        end
        q.push_back(e);
    endtask

    // One clock: check the output due now, then drive the next input.
    task automatic cycle(input logic en, input logic [31:0] cur, input logic [31:0] bg,
                         input logic [7:0] thr);
        exp_t e;
        @(negedge clk);
        e = q.pop_front();
        chk("pixel_valid",   {31'd0, pixel_valid},   {31'd0, e.valid});
        chk("motion_pixel",  {31'd0, motion_pixel},  {31'd0, e.motion});
        chk("last_in_frame", {31'd0, last_in_frame}, {31'd0, e.last});
        chk("rbg_pixel",     rbg_pixel,              e.rbg);
        chk("bg_pixel_out",  bg_pixel_out,           e.bgo);
        enable       = en;
        rbg_pixel_in = cur;
        bg_pixel_in  = bg;
        threshold    = thr;
        model_push(en, cur, bg, thr);
    endtask

    // Hold reset with live toggling inputs. Outputs must read zero. Then release.
    task automatic do_reset(input int ncyc, input int w, input int h);
        exp_t z;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst          = 1'b0;
            enable       = 1'($urandom);
            rbg_pixel_in = $urandom;
            bg_pixel_in  = $urandom;
            width        = 11'(w);
            height       = 10'(h);
            #1;
            chk("rst_valid",  {31'd0, pixel_valid},   32'd0);
            chk("rst_motion", {31'd0, motion_pixel},  32'd0);
            chk("rst_last",   {31'd0, last_in_frame}, 32'd0);
            chk("rst_rbg",    rbg_pixel,              32'd0);
            chk("rst_bgo",    bg_pixel_out,           32'd0);
        end
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b1;
        m_idx = 0; m_frame = 0; m_w = w; m_h = h;
        m_last_rbg = 32'd0; m_last_bgo = 32'd0;
        z.valid = 1'b0; z.motion = 1'b0; z.last = 1'b0; z.rbg = 32'd0; z.bgo = 32'd0;
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back(z);
    endtask

    initial begin
        // Reset, then two 4x2 frames of strongly differing data: warmup, then run.
        do_reset(4, 4, 2);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++)
                cycle(1'b1, 32'h00FFFFFF, 32'h00000000, 8'd10);

        // Threshold boundary in run: luma 100 vs 90.
        cycle(1'b1, 32'h00646464, 32'h005A5A5A, 8'd10);
        cycle(1'b1, 32'h00646464, 32'h005A5A5A, 8'd9);
        cycle(1'b1, 32'h005A5A5A, 32'h00646464, 8'd9);

        // Bubble pattern 1,0,1,1,0.
        cycle(1'b1, $urandom, $urandom, 8'($urandom));
        cycle(1'b0, $urandom, $urandom, 8'($urandom));
        cycle(1'b1, $urandom, $urandom, 8'($urandom));
        cycle(1'b1, $urandom, $urandom, 8'($urandom));
        cycle(1'b0, $urandom, $urandom, 8'($urandom));

        // Background running-average corner cases.
        cycle(1'b1, 32'hAB909090, 32'h5C101010, 8'd0);
        cycle(1'b1, 32'h00101010, 32'h00909090, 8'd0);

        // Random traffic with random bubbles.
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 8'($urandom_range(0, 80)));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 8'd0);

        // Mid-frame reset after 3 pixels. The restart must be at (0,0) in warmup.
        do_reset(3, 3, 3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00FFFFFF, 32'h00000000, 8'd5);
        do_reset(2, 3, 3);
        for (int i = 0; i < 18; i++) cycle(1'b1, 32'h00FFFFFF, 32'h00000000, 8'd5);
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom_range(0, 60)));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 8'd0);

        // Degenerate 1x1 frame: every pixel is last, and only the first is warmup.
        do_reset(2, 1, 1);
        for (int i = 0; i < 30; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 8'($urandom_range(0, 60)));
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 32'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
